// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX datapath.
// Includes the FCS state encoding, CRC constants and the byte bit-reversal helper.
package eth_pkg;

  typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_FCS} tx_fcs_state_t;

  localparam int          ETH_MIN_FRAME = 60;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/ethernet_crc32.sv
// Byte-wide IEEE 802.3 CRC32 engine, one byte per enabled cycle.
// Bits enter LSB first into a non-reflected register, so crc_out is the MSB-first remainder.
module ethernet_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 8; i++) begin
      crc_d = {crc_d[30:0], 1'b0} ^ ((crc_d[31] ^ data_in[i]) ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= CRC_INIT;
    end else if (crc_en) begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/eth_tx_fcs_inserter.sv
// TX MAC stage: forwards payload bytes, zero-pads short frames and appends the 4-byte FCS.
// One output register stage; back-to-back frames with no idle cycle between FCS and next DA.
module eth_tx_fcs_inserter
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready
);

  localparam logic [CNT_W:0] MIN_W = (CNT_W+1)'(MIN_FRAME_BYTES);

  tx_fcs_state_t    state_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       fcs_idx_q;
  logic [7:0]       m_data_q;
  logic             m_valid_q;
  logic             m_last_q;

  logic             load_ok;
  logic [CNT_W:0]   count_inc_w;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W+1:0] pad_gap;
  logic             pad_needed;
  logic             crc_en;
  logic [7:0]       crc_data;
  logic             frame_done;
  logic [31:0]      crc_out;
  logic [7:0]       crc_byte;
  logic [7:0]       fcs_byte;

  assign load_ok = !m_valid_q | m_ready;
  assign s_ready = (state_q == ST_DATA) & load_ok & !reset;

  // Counter saturates; padding decisions use the unsaturated +1 so they stay exact.
  assign count_inc_w = {1'b0, count_q} + (CNT_W+1)'(1);
  assign count_d     = (&count_q) ? count_q : count_inc_w[CNT_W-1:0];
  assign pad_gap     = {1'b0, MIN_W} - {1'b0, count_inc_w};
  assign pad_needed  = !pad_gap[CNT_W+1] && (pad_gap != '0);

  assign crc_en     = load_ok & (((state_q == ST_DATA) & s_valid) | (state_q == ST_PAD));
  assign crc_data   = (state_q == ST_DATA) ? s_data : 8'h00;
  assign frame_done = load_ok & (state_q == ST_FCS) & (fcs_idx_q == 2'd3);

  ethernet_crc32 u_crc (
    .clk     (clk),
    .reset   (reset | frame_done),
    .crc_en  (crc_en),
    .data_in (crc_data),
    .crc_out (crc_out)
  );

  always_comb begin
    crc_byte = crc_out[31:24];
    unique case (fcs_idx_q)
      2'd0: crc_byte = crc_out[31:24];
      2'd1: crc_byte = crc_out[23:16];
      2'd2: crc_byte = crc_out[15:8];
      2'd3: crc_byte = crc_out[7:0];
    endcase
    fcs_byte = ~bitrev8(crc_byte);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_DATA;
      count_q   <= '0;
      fcs_idx_q <= 2'd0;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (load_ok) begin
      unique case (state_q)
        ST_DATA: begin
          m_valid_q <= s_valid;
          m_last_q  <= 1'b0;
          if (s_valid) begin
            m_data_q <= s_data;
            count_q  <= count_d;
            if (s_last) state_q <= pad_needed ? ST_PAD : ST_FCS;
          end
        end
        ST_PAD: begin
          m_valid_q <= 1'b1;
          m_last_q  <= 1'b0;
          m_data_q  <= 8'h00;
          count_q   <= count_d;
          if (!pad_needed) state_q <= ST_FCS;
        end
        ST_FCS: begin
          m_valid_q <= 1'b1;
          m_data_q  <= fcs_byte;
          m_last_q  <= (fcs_idx_q == 2'd3);
          fcs_idx_q <= fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            state_q <= ST_DATA;
            count_q <= '0;
          end
        end
        default: state_q <= ST_DATA;
      endcase
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_eth_tx_fcs_inserter.sv
// Bench for eth_tx_fcs_inserter: two instances (default minimum frame and no padding),
// random payloads and backpressure, compared against a byte-queue reference with a reflected CRC32.
module tb_eth_tx_fcs_inserter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;
  logic       sel = 1'b0;

  logic       a_s_valid, a_s_ready, a_m_valid, a_m_last;
  logic [7:0] a_m_data;
  logic       b_s_valid, b_s_ready, b_m_valid, b_m_last;
  logic [7:0] b_m_data;
  logic       s_ready_x, m_valid_x, m_last_x;
  logic [7:0] m_data_x;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [7:0] pay[$];
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  logic [7:0] out_d[$];
  logic       out_l[$];
  int         out_c[$];
  int         acc_c[$];

  always #5 clk = ~clk;

  assign a_s_valid = s_valid & ~sel;
  assign b_s_valid = s_valid & sel;
  assign s_ready_x = sel ? b_s_ready : a_s_ready;
  assign m_valid_x = sel ? b_m_valid : a_m_valid;
  assign m_last_x  = sel ? b_m_last  : a_m_last;
  assign m_data_x  = sel ? b_m_data  : a_m_data;

  eth_tx_fcs_inserter dut_a (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(a_s_valid), .s_last(s_last), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_last(a_m_last), .m_ready(m_ready)
  );

  eth_tx_fcs_inserter #(.MIN_FRAME_BYTES(0)) dut_b (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(b_s_valid), .s_last(s_last), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_last(b_m_last), .m_ready(m_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && m_valid_x && m_ready) begin
      out_d.push_back(m_data_x);
      out_l.push_back(m_last_x);
      out_c.push_back(cyc);
    end
    if (!reset && s_valid && s_ready_x) acc_c.push_back(cyc);
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = ($urandom_range(3) != 0);
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] get_d(input int i);
    return (i < out_d.size()) ? out_d[i] : 8'hxx;
  endfunction

  function automatic int get_oc(input int i);
    return (i < out_c.size()) ? out_c[i] : -1;
  endfunction

  function automatic int get_ac(input int i);
    return (i < acc_c.size()) ? acc_c[i] : -2;
  endfunction

  // Reference: pad to the minimum, standard reflected CRC32, FCS sent low byte first.
  function automatic void add_expected(input int min_bytes);
    logic [7:0]  fr[$];
    logic [31:0] c;
    fr = pay;
    while (fr.size() < min_bytes) fr.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (fr[i]) begin
      c = c ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    foreach (fr[i]) begin
      exp_d.push_back(fr[i]);
      exp_l.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_d.push_back(c[8*k +: 8]);
      exp_l.push_back(k == 3);
    end
  endfunction

  task automatic clear_all();
    out_d.delete(); out_l.delete(); out_c.delete(); acc_c.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  task automatic send_frame(input int gap_pct, input bit with_last);
    bit acc;
    int w;
    for (int i = 0; i < pay.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = pay[i];
      s_last  = with_last && (i == pay.size() - 1);
      w = 0;
      do begin
        @(negedge clk);
        acc = s_ready_x;
        @(posedge clk); #1;
        w++;
      end while (!acc && w < 200);
      if (!acc) chk("send_timeout", 32'(w), 32'(0));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int t;
    int n;
    n = exp_d.size();
    t = 0;
    while (out_d.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk({tag, " beats"}, 32'(out_d.size()), 32'(n));
    for (int i = 0; i < n && i < out_d.size(); i++) begin
      chk($sformatf("%s data[%0d]", tag, i), {24'h0, out_d[i]}, {24'h0, exp_d[i]});
      chk($sformatf("%s last[%0d]", tag, i), {31'h0, out_l[i]}, {31'h0, exp_l[i]});
    end
  endtask

  initial begin
    // reset state
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst m_valid", {31'h0, a_m_valid}, 32'h0);
    chk("rst m_last",  {31'h0, a_m_last},  32'h0);
    chk("rst m_data",  {24'h0, a_m_data},  32'h0);
    chk("rst s_ready", {31'h0, a_s_ready}, 32'h0);
    chk("rst s_ready_b", {31'h0, b_s_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: no padding, check value "123456789"
    sel = 1'b1; rdy_mode = 0;
    clear_all();
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    add_expected(0);
    send_frame(0, 1'b1);
    check_stream("t1");
    chk("t1 fcs0", {24'h0, get_d(9)},  32'h26);
    chk("t1 fcs1", {24'h0, get_d(10)}, 32'h39);
    chk("t1 fcs2", {24'h0, get_d(11)}, 32'hF4);
    chk("t1 fcs3", {24'h0, get_d(12)}, 32'hCB);
    chk("t1 span", 32'(get_oc(12) - get_oc(0)), 32'd12);
    chk("t1 latency", 32'(get_oc(0) - get_ac(0)), 32'd1);

    // 2: short frame padded to 60, random input gaps
    sel = 1'b0; rdy_mode = 0;
    clear_all();
    pay.delete();
    for (int i = 0; i < 14; i++) pay.push_back(8'(i));
    add_expected(60);
    send_frame(20, 1'b1);
    check_stream("t2");

    // 3: 64 random bytes, toggling backpressure
    rdy_mode = 1;
    clear_all();
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'($urandom_range(255)));
    add_expected(60);
    send_frame(0, 1'b1);
    check_stream("t3");

    // 4: two back-to-back 60-byte frames
    rdy_mode = 0;
    @(posedge clk); #1;
    clear_all();
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'($urandom_range(255)));
    add_expected(60);
    send_frame(0, 1'b1);
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'($urandom_range(255)));
    add_expected(60);
    send_frame(0, 1'b1);
    check_stream("t4");
    chk("t4 b2b", 32'(get_ac(60)), 32'(get_oc(63)));

    // 5: reset mid-frame, then a clean frame
    sel = 1'b1; rdy_mode = 0;
    clear_all();
    pay.delete();
    for (int i = 0; i < 19; i++) pay.push_back(8'($urandom_range(255)));
    send_frame(0, 1'b0);
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t5 s_ready_in_rst", {31'h0, s_ready_x}, 32'h0);
    @(negedge clk);
    chk("t5 m_valid_after", {31'h0, m_valid_x}, 32'h0);
    chk("t5 s_ready_after", {31'h0, s_ready_x}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    clear_all();
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    add_expected(0);
    send_frame(0, 1'b1);
    check_stream("t5");
    chk("t5 fcs3", {24'h0, get_d(12)}, 32'hCB);

    // 6: single-byte payload, random backpressure
    sel = 1'b0; rdy_mode = 2;
    clear_all();
    pay.delete();
    pay.push_back(8'hAA);
    add_expected(60);
    send_frame(0, 1'b1);
    check_stream("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
